mpu_store_writeback: RTL and testbench

//  Downstream of mpu_store. Captures the row-major element stream that mpu_store emits
//  (mem_store_en / element / M / N) and writes it to external memory at base + i*N + j.

---
 rtl/mpu_pkg.sv | 20 ++
 rtl/mpu_store_writeback_if.sv | 24 ++
 rtl/mpu_wb_fifo.sv | 45 ++++
 rtl/mpu_store_writeback.sv | 182 ++++++++++++++++++
 tb/tb_mpu_store_writeback.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_pkg.sv
// Shared MPU definitions: element/size geometry and the store-writeback state encoding.
package mpu_pkg;

  localparam int FPBITS = 31;
  localparam int MBITS  = 2;
  localparam int NBITS  = 2;
  localparam int M_MEM  = 3;
  localparam int N_MEM  = 3;

  localparam int WB_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    WB_IDLE,
    WB_ARMED,
    WB_STREAM,
    WB_DRAIN,
    WB_DONE
  } wb_state_t;

endpackage

// File: rtl/mpu_store_writeback_if.sv
// External memory write port: valid/ready handshake carrying a word address and data.
interface mpu_store_writeback_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              ext_wr_valid_out;
  logic              ext_wr_ready_in;
  logic [ADDR_W-1:0] ext_wr_addr_out;
  logic [DATA_W-1:0] ext_wr_data_out;

  modport master (
    output ext_wr_valid_out,
    output ext_wr_addr_out,
    output ext_wr_data_out,
    input  ext_wr_ready_in
  );

  modport slave (
    input  ext_wr_valid_out,
    input  ext_wr_addr_out,
    input  ext_wr_data_out,
    output ext_wr_ready_in
  );
endinterface

// File: rtl/mpu_wb_fifo.sv
// Synchronous FIFO absorbing memory backpressure; a push on a full FIFO is taken only with a pop.
module mpu_wb_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             push_ok;
  logic             pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count   = wp - rp;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/mpu_store_writeback.sv
// Writes the mpu_store row-major element stream to memory at base + i*N + j.
// Optional MPU_WB_SIZE_CHECK_EN: range-check M/N on the first element and flag size changes mid-stream.
module mpu_store_writeback
  import mpu_pkg::*;
#(
  parameter int DATA_W     = FPBITS + 1,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
`ifdef MPU_WB_SIZE_CHECK_EN
  ,
  parameter int M_MAX      = M_MEM,
  parameter int N_MAX      = N_MEM
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_start_in,
  input  logic [ADDR_W-1:0]  wb_base_addr_in,
  input  logic               mem_store_en_in,
  input  logic [DATA_W-1:0]  mem_store_element_in,
  input  logic [MBITS:0]     mem_m_store_size_in,
  input  logic [NBITS:0]     mem_n_store_size_in,
  mpu_store_writeback_if.master wr,
  output logic               wb_busy_out,
  output logic               wb_done_out,
  output logic               wb_error_out
);
  localparam int MW = MBITS + 1;
  localparam int NW = NBITS + 1;
  localparam int FW = ADDR_W + DATA_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_t         state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [MW-1:0]     m_q;
  logic [MW-1:0]     i_q;
  logic [NW-1:0]     n_q;
  logic [NW-1:0]     j_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              armed;
  logic              take;
  logic              size_bad;
  logic              row_end;
  logic              last_elem;
  logic              push_vld;
  logic              pop;
  logic              drop;
  logic [MW-1:0]     cur_m;
  logic [MW-1:0]     cur_i;
  logic [NW-1:0]     cur_n;
  logic [NW-1:0]     cur_j;
  logic [ADDR_W-1:0] cur_rb;
  logic [ADDR_W-1:0] push_addr;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [FW-1:0]     fifo_head;

  // In ARMED the first element uses the live sizes and a zero position, so it needs no extra cycle.
  always_comb begin
    armed     = (state == WB_ARMED);
    take      = mem_store_en_in && (armed || (state == WB_STREAM));
    cur_m     = armed ? mem_m_store_size_in : m_q;
    cur_n     = armed ? mem_n_store_size_in : n_q;
    cur_i     = armed ? '0 : i_q;
    cur_j     = armed ? '0 : j_q;
    cur_rb    = armed ? base_q : row_base_q;
    size_bad  = (mem_m_store_size_in == '0) || (mem_n_store_size_in == '0);
`ifdef MPU_WB_SIZE_CHECK_EN
    size_bad  = size_bad || (int'(mem_m_store_size_in) > M_MAX) ||
                (int'(mem_n_store_size_in) > N_MAX);
`endif
    row_end   = (cur_j == cur_n - NW'(1));
    last_elem = row_end && (cur_i == cur_m - MW'(1));
    push_vld  = take && !(armed && size_bad);
    push_addr = cur_rb + ADDR_W'(cur_j);
    pop       = !fifo_empty && wr.ext_wr_ready_in;
    drop      = push_vld && fifo_full && !pop;
  end

  mpu_wb_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_vld && !drop),
    .push_data ({push_addr, mem_store_element_in}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign wr.ext_wr_valid_out = !fifo_empty;
  assign wr.ext_wr_addr_out  = fifo_empty ? '0 : fifo_head[FW-1:DATA_W];
  assign wr.ext_wr_data_out  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign wb_busy_out         = busy_q;
  assign wb_done_out         = done_q;
  assign wb_error_out        = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WB_IDLE;
      base_q     <= '0;
      row_base_q <= '0;
      m_q        <= '0;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (drop) err_q <= 1'b1;

      // Dropped elements still advance the position so the count reaches M*N.
      if (push_vld) begin
        if (row_end) begin
          j_q        <= '0;
          i_q        <= cur_i + MW'(1);
          row_base_q <= cur_rb + ADDR_W'(cur_n);
        end else begin
          j_q        <= cur_j + NW'(1);
          i_q        <= cur_i;
          row_base_q <= cur_rb;
        end
      end

      case (state)
        WB_IDLE, WB_DONE: begin
          state <= WB_IDLE;
          if (wb_start_in) begin
            state  <= WB_ARMED;
            base_q <= wb_base_addr_in;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        WB_ARMED: begin
          if (mem_store_en_in) begin
            m_q <= mem_m_store_size_in;
            n_q <= mem_n_store_size_in;
            if (size_bad) begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= WB_DONE;
            end else if (last_elem) begin
              state <= WB_DRAIN;
            end else begin
              state <= WB_STREAM;
            end
          end
        end
        WB_STREAM: begin
          if (mem_store_en_in) begin
`ifdef MPU_WB_SIZE_CHECK_EN
            if ((mem_m_store_size_in != m_q) || (mem_n_store_size_in != n_q)) err_q <= 1'b1;
`endif
            if (last_elem) state <= WB_DRAIN;
          end
        end
        WB_DRAIN: begin
          if (fifo_empty || (pop && (fifo_cnt == CW'(1)))) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= WB_DONE;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpu_store_writeback.sv
// Directed-vector bench for mpu_store_writeback with hand-computed addresses and FP data.
module tb_mpu_store_writeback;
  import mpu_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam logic [31:0] FP_TAB [9] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
    32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000
  };

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              wb_start = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic              en = 1'b0;
  logic [DATA_W-1:0] elem = '0;
  logic [MBITS:0]    m_sz = '0;
  logic [NBITS:0]    n_sz = '0;
  logic              busy;
  logic              done;
  logic              err;

  int n_vec  = 0;
  int n_miss = 0;
  int wr_n = 0, done_n = 0, cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  logic [15:0] wa [256];
  logic [31:0] wd [256];

  mpu_store_writeback_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

  mpu_store_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .wb_start_in          (wb_start),
    .wb_base_addr_in      (base),
    .mem_store_en_in      (en),
    .mem_store_element_in (elem),
    .mem_m_store_size_in  (m_sz),
    .mem_n_store_size_in  (n_sz),
    .wr                   (wr_if),
    .wb_busy_out          (busy),
    .wb_done_out          (done),
    .wb_error_out         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_if.ext_wr_valid_out && wr_if.ext_wr_ready_in) begin
      if (wr_n < 256) begin
        wa[wr_n] <= wr_if.ext_wr_addr_out;
        wd[wr_n] <= wr_if.ext_wr_data_out;
      end
      wr_n        <= wr_n + 1;
      last_wr_cyc <= cyc;
    end
    if (done) begin
      done_n   <= done_n + 1;
      done_cyc <= cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [15:0] b);
    wb_start = 1'b1;
    base     = b;
    tick();
    wb_start = 1'b0;
  endtask

  task automatic stream(input int m, input int n, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      en   = 1'b1;
      elem = FP_TAB[k];
      m_sz = (MBITS+1)'(m);
      n_sz = (NBITS+1)'(n);
      tick();
    end
    en = 1'b0;
  endtask

  task automatic wait_done(input string t, input int d0);
    int k = 0;
    while (done_n == d0 && k < 80) begin
      tick();
      k++;
    end
    repeat (3) tick();
    chk({t, "_done_once"}, 32'(done_n - d0), 32'd1);
    chk({t, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string t, input int w0, input int n, input logic [15:0] a0);
    logic [15:0] a;
    chk({t, "_wr_count"}, 32'(wr_n - w0), 32'(n));
    for (int k = 0; k < n && k < wr_n - w0; k++) begin
      a = a0 + 16'(k);
      chk($sformatf("%s_addr%0d", t, k), 32'(wa[w0+k]), 32'(a));
      chk($sformatf("%s_data%0d", t, k), wd[w0+k], FP_TAB[k]);
    end
  endtask

  initial begin
    int w0, d0;
    wr_if.ext_wr_ready_in = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(wr_if.ext_wr_valid_out), 0);
    chk("rst_addr", 32'(wr_if.ext_wr_addr_out), 0);
    chk("rst_data", wr_if.ext_wr_data_out, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b1;
    tick();

    // 1: 3x3 at 0x0100, ready always high
    w0 = wr_n; d0 = done_n;
    arm(16'h0100);
    chk("t1_busy_armed", 32'(busy), 1);
    stream(3, 3, 9);
    wait_done("t1", d0);
    check_writes("t1", w0, 9, 16'h0100);
    chk("t1_done_latency", 32'(done_cyc - last_wr_cyc), 1);
    chk("t1_err", 32'(err), 0);

    // 2: 2x2 at 0x0020, ready low for the first 3 valid cycles
    wr_if.ext_wr_ready_in = 1'b0;
    w0 = wr_n; d0 = done_n;
    arm(16'h0020);
    for (int k = 0; k < 4; k++) begin
      en = 1'b1; elem = FP_TAB[k]; m_sz = 3'd2; n_sz = 3'd2;
      tick();
      if (k < 3) begin
        chk($sformatf("t2_hold_valid%0d", k), 32'(wr_if.ext_wr_valid_out), 1);
        chk($sformatf("t2_hold_addr%0d", k), 32'(wr_if.ext_wr_addr_out), 32'h20);
        chk($sformatf("t2_hold_data%0d", k), wr_if.ext_wr_data_out, FP_TAB[0]);
      end
      if (k == 2) wr_if.ext_wr_ready_in = 1'b1;
    end
    en = 1'b0;
    wait_done("t2", d0);
    check_writes("t2", w0, 4, 16'h0020);
    chk("t2_err", 32'(err), 0);

    // 2b: full FIFO with simultaneous push and pop loses nothing
    wr_if.ext_wr_ready_in = 1'b0;
    w0 = wr_n; d0 = done_n;
    arm(16'h0040);
    for (int k = 0; k < 9; k++) begin
      en = 1'b1; elem = FP_TAB[k]; m_sz = 3'd3; n_sz = 3'd3;
      if (k == 4) wr_if.ext_wr_ready_in = 1'b1;
      tick();
    end
    en = 1'b0;
    wait_done("t2b", d0);
    check_writes("t2b", w0, 9, 16'h0040);
    chk("t2b_err", 32'(err), 0);

    // 3: 3x3 with ready low throughout; the 5th element overflows
    wr_if.ext_wr_ready_in = 1'b0;
    w0 = wr_n; d0 = done_n;
    arm(16'h0100);
    chk("t3_err_cleared", 32'(err), 0);
    for (int k = 0; k < 9; k++) begin
      en = 1'b1; elem = FP_TAB[k]; m_sz = 3'd3; n_sz = 3'd3;
      tick();
      if (k == 3) chk("t3_err_before_drop", 32'(err), 0);
      if (k == 4) chk("t3_err_after_drop", 32'(err), 1);
    end
    en = 1'b0;
    chk("t3_busy_stalled", 32'(busy), 1);
    wr_if.ext_wr_ready_in = 1'b1;
    wait_done("t3", d0);
    check_writes("t3", w0, 4, 16'h0100);
    chk("t3_err_sticky", 32'(err), 1);

    // 4: address wrap from 0xFFFE
    w0 = wr_n; d0 = done_n;
    arm(16'hFFFE);
    chk("t4_err_cleared", 32'(err), 0);
    stream(2, 2, 4);
    wait_done("t4", d0);
    check_writes("t4", w0, 4, 16'hFFFE);
    chk("t4_done_latency", 32'(done_cyc - last_wr_cyc), 1);

    // 5: reset mid-stream, then a clean 2x2
    d0 = done_n;
    arm(16'h0100);
    stream(3, 3, 4);
    rst = 1'b0;
    #1;
    chk("t5_valid_rst", 32'(wr_if.ext_wr_valid_out), 0);
    chk("t5_addr_rst", 32'(wr_if.ext_wr_addr_out), 0);
    chk("t5_busy_rst", 32'(busy), 0);
    chk("t5_err_rst", 32'(err), 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("t5_no_done", 32'(done_n - d0), 0);
    w0 = wr_n; d0 = done_n;
    arm(16'h0010);
    stream(2, 2, 4);
    wait_done("t5", d0);
    check_writes("t5", w0, 4, 16'h0010);

    // 6: M=4 exceeds M_MAX=3 only when the size check is built in
    w0 = wr_n; d0 = done_n;
    arm(16'h0200);
    stream(4, 2, 8);
    wait_done("t6", d0);
`ifdef MPU_WB_SIZE_CHECK_EN
    check_writes("t6", w0, 0, 16'h0200);
    chk("t6_err", 32'(err), 1);
`else
    check_writes("t6", w0, 8, 16'h0200);
    chk("t6_err", 32'(err), 0);
`endif

    // 7: zero row count goes straight to done with error
    w0 = wr_n; d0 = done_n;
    arm(16'h0300);
    stream(0, 3, 1);
    wait_done("t7", d0);
    check_writes("t7", w0, 0, 16'h0300);
    chk("t7_err", 32'(err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
